fft_bitrev_reorder: RTL and testbench

- Streaming bit-reversal reorder buffer for the FFT datapath. Generalises the fixed 6-bit index flip to N = 2^LOG2N samples of DATA_W bits.
- Accepts samples in natural order and emits each frame in bit-reversed order, with the bit-reversed source index alongside.
- Ping-pong double buffer: one frame is written while the previous one is read. Valid/ready handshakes on both sides.
- Sits between sample capture and the first butterfly stage.

---
 rtl/fft_bitrev_reorder.sv | 148 ++++++++++++++
 tb/tb_fft_bitrev_reorder.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_bitrev_reorder.sv
// Ping-pong frame buffer: natural-order samples in, bit-reversed order out, 1 cycle after a frame completes.
// Define BITREV_BYPASS_EN to add a per-frame bypass input that selects natural-order output.
module fft_bitrev_reorder #(
  parameter int LOG2N  = 6,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
`ifdef BITREV_BYPASS_EN
  input  logic              bypass,
`endif
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [LOG2N-1:0]  out_index,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic [7:0]        frame_cnt
);

  localparam int N = 1 << LOG2N;
  localparam logic [LOG2N-1:0] LAST_IDX = {LOG2N{1'b1}};

  logic [DATA_W-1:0] bank0_q [N];
  logic [DATA_W-1:0] bank1_q [N];

  logic [1:0]        full_q, full_d;
  logic              wr_bank_q, wr_bank_d;
  logic              rd_bank_q, rd_bank_d;
  logic [LOG2N-1:0]  wr_cnt_q, wr_cnt_d;
  logic [LOG2N-1:0]  rd_cnt_q, rd_cnt_d;
  logic              out_valid_q, out_valid_d;
  logic              out_last_q, out_last_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [LOG2N-1:0]  out_index_q, out_index_d;
  logic [7:0]        frame_cnt_q, frame_cnt_d;

  logic              wr_fire, rd_load;
  logic [LOG2N-1:0]  rd_rev, rd_addr;
  logic [DATA_W-1:0] rd_word;

  // in_ready comes from registered state only, so a bank freed this cycle is visible next cycle.
  assign in_ready = !full_q[wr_bank_q];
  assign wr_fire  = in_valid && in_ready;
  assign rd_load  = full_q[rd_bank_q] && (!out_valid_q || out_ready);

  for (genvar k = 0; k < LOG2N; k++) begin : g_rev
    assign rd_rev[k] = rd_cnt_q[LOG2N-1-k];
  end

`ifdef BITREV_BYPASS_EN
  logic bypass_q, bypass_d, bypass_eff;

  // Bypass is captured on the first load of a frame and held until the frame ends.
  assign bypass_eff = (rd_cnt_q == '0) ? bypass : bypass_q;
  assign bypass_d   = (rd_load && (rd_cnt_q == '0)) ? bypass : bypass_q;
  assign rd_addr    = bypass_eff ? rd_cnt_q : rd_rev;

  always_ff @(posedge clk) begin
    if (!rst) bypass_q <= 1'b0;
    else      bypass_q <= bypass_d;
  end
`else
  assign rd_addr = rd_rev;
`endif

  assign rd_word = rd_bank_q ? bank1_q[rd_addr] : bank0_q[rd_addr];

  always_ff @(posedge clk) begin
    if (wr_fire) begin
      if (wr_bank_q) bank1_q[wr_cnt_q] <= in_data;
      else           bank0_q[wr_cnt_q] <= in_data;
    end
  end

  always_comb begin
    full_d      = full_q;
    wr_bank_d   = wr_bank_q;
    rd_bank_d   = rd_bank_q;
    wr_cnt_d    = wr_cnt_q;
    rd_cnt_d    = rd_cnt_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_data_d  = out_data_q;
    out_index_d = out_index_q;
    frame_cnt_d = frame_cnt_q;

    if (wr_fire) begin
      wr_cnt_d = wr_cnt_q + LOG2N'(1);
      if (wr_cnt_q == LAST_IDX) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = ~wr_bank_q;
      end
    end

    // Write and read banks always differ, so both flag updates can land in one cycle.
    if (rd_load) begin
      out_data_d  = rd_word;
      out_index_d = rd_addr;
      out_last_d  = (rd_cnt_q == LAST_IDX);
      out_valid_d = 1'b1;
      rd_cnt_d    = rd_cnt_q + LOG2N'(1);
      if (rd_cnt_q == LAST_IDX) begin
        full_d[rd_bank_q] = 1'b0;
        rd_bank_d         = ~rd_bank_q;
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end

    if (out_valid_q && out_ready && out_last_q) frame_cnt_d = frame_cnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      full_q      <= '0;
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      wr_cnt_q    <= '0;
      rd_cnt_q    <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      out_index_q <= '0;
      frame_cnt_q <= '0;
    end else begin
      full_q      <= full_d;
      wr_bank_q   <= wr_bank_d;
      rd_bank_q   <= rd_bank_d;
      wr_cnt_q    <= wr_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
      out_index_q <= out_index_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_index = out_index_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Randomised bench for fft_bitrev_reorder (LOG2N=3) against a frame-level reorder model.
`timescale 1ns/1ps
module tb_fft_bitrev_reorder;
  localparam int LOG2N  = 3;
  localparam int DATA_W = 16;
  localparam int N      = 1 << LOG2N;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] out_data;
  logic [LOG2N-1:0]  out_index;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic              out_last;
  logic [7:0]        frame_cnt;
`ifdef BITREV_BYPASS_EN
  logic              bypass = 1'b0;
`endif

  fft_bitrev_reorder #(.LOG2N(LOG2N), .DATA_W(DATA_W)) dut (
    .clk      (clk),
    .rst      (rst),
`ifdef BITREV_BYPASS_EN
    .bypass   (bypass),
`endif
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_index(out_index),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_last (out_last),
    .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  typedef struct { int dat; int idx; bit last; } exp_t;

  int   part_q[$];
  exp_t exp_q[$];
  bit   mode_q[$];
  int   log_q[$];
  int   bubbles = 0;
  int   rdy_mode = 1;
  int   tbl[8] = '{0, 4, 2, 6, 1, 5, 3, 7};

  function automatic int brev(input int k);
    int r = 0;
    for (int b = 0; b < LOG2N; b++) r = r * 2 + (k / (1 << b)) % 2;
    return r;
  endfunction

  // Model: a completed input frame expands into N expected outputs in read order.
  task automatic model_frame_done();
    bit m = 1'b0;
    int src;
    exp_t e;
    if (mode_q.size() > 0) m = mode_q.pop_front();
    for (int p = 0; p < N; p++) begin
      src    = m ? p : brev(p);
      e.dat  = part_q[src];
      e.idx  = src;
      e.last = (p == N - 1);
      exp_q.push_back(e);
    end
    part_q.delete();
  endtask

  bit                stall_pend = 1'b0;
  logic [DATA_W-1:0] held_dat;
  logic [LOG2N-1:0]  held_idx;
  logic              held_last;

  always @(negedge clk) begin
    if (!rst) begin
      stall_pend = 1'b0;
    end else begin
      if (stall_pend) begin
        chk("hold_data", out_data, held_dat);
        chk("hold_index", out_index, held_idx);
        chk("hold_last", out_last, held_last);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("spurious_out", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("out_data", out_data, e.dat);
          chk("out_index", out_index, e.idx);
          chk("out_last", out_last, e.last);
        end
        log_q.push_back(int'(out_data));
      end
      stall_pend = out_valid && !out_ready;
      held_dat   = out_data;
      held_idx   = out_index;
      held_last  = out_last;
      if (in_valid && in_ready) begin
        part_q.push_back(int'(in_data));
        if (part_q.size() == N) model_frame_done();
      end
    end
  end

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  task automatic send(input int v);
    int waited = 0;
    bit acc;
    in_data  = DATA_W'(v);
    in_valid = 1'b1;
    forever begin
      acc = in_ready;
      @(posedge clk); #1;
      if (acc) break;
      bubbles++;
      waited++;
      if (waited > 500) begin
        chk("send_timeout", 0, 1);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int cyc = 0;
    while ((exp_q.size() != 0 || out_valid) && cyc < 3000) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("drained", exp_q.size(), 0);
  endtask

  task automatic check_table(input string tag, input int base);
    for (int i = 0; i < N; i++)
      chk($sformatf("%s_%0d", tag, i), (log_q.size() > base + i) ? log_q[base + i] : -1, tbl[i]);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_frame_cnt", frame_cnt, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_index", out_index, 0);
    chk("rst_out_last", out_last, 0);

    // Single frame, first-output latency and fixed order
    log_q.delete();
    for (int v = 0; v < N - 1; v++) send(v);
    send(N - 1);
    chk("lat_pre_valid", out_valid, 0);
    @(posedge clk); #1;
    chk("lat_first_valid", out_valid, 1);
    chk("lat_first_data", out_data, 0);
    drain();
    chk("t1_count", log_q.size(), N);
    check_table("t1_order", 0);
    chk("t1_frame_cnt", frame_cnt, 1);

    // Four back-to-back frames
    bubbles = 0;
    for (int v = 0; v < 4 * N; v++) send(v);
    drain();
    chk("t2_bubbles_ok", bubbles <= 4, 1);
    chk("t2_frame_cnt", frame_cnt, 5);

    // Output stalled while two frames arrive
    rdy_mode  = 0;
    out_ready = 1'b0;
    for (int v = 0; v < 2 * N; v++) send(v);
    chk("t3_in_ready_low", in_ready, 0);
    chk("t3_out_valid", out_valid, 1);
    chk("t3_out_data", out_data, 0);
    repeat (5) @(posedge clk);
    #1;
    chk("t3_in_ready_still_low", in_ready, 0);
    chk("t3_out_data_held", out_data, 0);
    rdy_mode  = 1;
    out_ready = 1'b1;
    drain();
    chk("t3_in_ready_back", in_ready, 1);
    chk("t3_frame_cnt", frame_cnt, 7);

    // Random backpressure, random data
    rdy_mode = 2;
    for (int f = 0; f < 10; f++)
      for (int i = 0; i < N; i++) send(int'($urandom_range(0, 65535)));
    rdy_mode = 1;
    drain();
    chk("t4_frame_cnt", frame_cnt, 17);

    // Reset in the middle of a frame
    for (int i = 0; i < 5; i++) send(100 + i);
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    part_q.delete();
    exp_q.delete();
    mode_q.delete();
    log_q.delete();
    chk("t5_rst_frame_cnt", frame_cnt, 0);
    chk("t5_rst_out_valid", out_valid, 0);
    chk("t5_rst_in_ready", in_ready, 1);
    for (int v = 0; v < N; v++) send(v);
    drain();
    chk("t5_count", log_q.size(), N);
    check_table("t5_order", 0);
    chk("t5_frame_cnt", frame_cnt, 1);

`ifdef BITREV_BYPASS_EN
    log_q.delete();
    mode_q.push_back(1'b1);
    mode_q.push_back(1'b0);
    bypass = 1'b1;
    for (int v = 0; v < N; v++) send(v);
    @(posedge clk); #1;
    bypass = 1'b0;
    for (int v = 0; v < N; v++) send(v);
    drain();
    for (int i = 0; i < N; i++)
      chk($sformatf("byp_nat_%0d", i), (log_q.size() > i) ? log_q[i] : -1, i);
    check_table("byp_rev", N);
    chk("byp_frame_cnt", frame_cnt, 3);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
